// File: rtl/mult_div_e.sv
// E-stage multiply/divide unit with architectural HI/LO registers.
// Operations run a fixed number of cycles; HI/LO update only on completion.
module mult_div_e (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUOut
);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } mdu_op_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    mdu_op_e     op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        md_start;
    logic        is_div_start;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] a_mag, b_mag, q_mag, r_mag;
    logic [31:0] q_s, r_s, q_u, r_u;

    // Results are formed from the latched operands and only committed on the final edge.
    always_comb begin
        prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        prod_u = {32'd0, a_q} * {32'd0, b_q};
        a_mag  = a_q[31] ? -a_q : a_q;
        b_mag  = b_q[31] ? -b_q : b_q;
        q_mag  = '0;
        r_mag  = '0;
        q_u    = '0;
        r_u    = '0;
        if (b_q != '0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
            q_u   = a_q / b_q;
            r_u   = a_q % b_q;
        end
        // Magnitude divide then re-sign; 0x80000000 / -1 wraps back to 0x80000000.
        q_s = (a_q[31] ^ b_q[31]) ? -q_mag : q_mag;
        r_s = a_q[31] ? -r_mag : r_mag;
    end

    always_comb begin
        md_start     = start && (MDUOp >= 4'd1) && (MDUOp <= 4'd4);
        is_div_start = (MDUOp == OP_DIV) || (MDUOp == OP_DIVU);

        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            IDLE: begin
                if (md_start) begin
                    op_d    = mdu_op_e'(MDUOp);
                    a_d     = A;
                    b_d     = B;
                    cnt_d   = is_div_start ? 4'd10 : 4'd5;
                    state_d = RUN;
                end else if (!start) begin
                    if (MDUOp == OP_MTHI) hi_d = A;
                    if (MDUOp == OP_MTLO) lo_d = A;
                end
            end
            RUN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    case (op_q)
                        OP_MULT:  {hi_d, lo_d} = prod_s;
                        OP_MULTU: {hi_d, lo_d} = prod_u;
                        OP_DIV: begin
                            if (b_q != '0) begin
                                hi_d = r_s;
                                lo_d = q_s;
                            end
                        end
                        OP_DIVU: begin
                            if (b_q != '0) begin
                                hi_d = r_u;
                                lo_d = q_u;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_NONE;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        busy      = (state_q == RUN);
        stall_req = busy || start;
        HI        = hi_q;
        LO        = lo_q;
        MDUOut    = '0;
        if (MDUOp == OP_MFHI) MDUOut = hi_q;
        if (MDUOp == OP_MFLO) MDUOut = lo_q;
    end

endmodule
